flags_unit: RTL and testbench
=============================

// Module: flags_unit
// PURPOSE
//  Holds the 8088 FLAGS register. Merges the six ALU status outputs into FLAGS
//  using a per-op update class. The ALU outputs lag the op by ALU_FLAG_LATENCY
//  edges, so the class is delayed to match. Also applies POPF/SAHF writes,
//  CLC/STC/CMC/CLD/STD/CLI/STI, and interrupt entry.
//  Supplies CF back to the ALU carryIn and raises a hazard flag while any ALU
//  flag update is still in flight.
// PARAMETERS
//  ALU_FLAG_LATENCY  2        edges from op issue to valid F_* outputs (>=1)
//  RESERVED_ONES     16'hF002 FLAGS bits forced to 1; bits 5,3 forced to 0
// PORTS
//  CLKx4          in   1   sole clock, all state on posedge
//  RESET          in   1   asynchronous, active-high
//  aluIssue       in   1   ALU op presented to ALU this cycle
//  aluClass       in   2   00 none, 01 ARITH, 10 INCDEC, 11 LOGIC
//  F_Overflow..F_Carry in 1 each  ALU flag outputs (OF,SF,ZF,AF,PF,CF)
//  flagWrite      in   1   direct write (POPF/SAHF)
//  flagWriteData  in   16  data for direct write
//  flagWriteMask  in   16  bits of FLAGS to replace (POPF FFFF, SAHF 00D5)
//  flagOp         in   3   0 none,1 CLC,2 STC,3 CMC,4 CLD,5 STD,6 CLI,7 STI
//  intEntry       in   1   interrupt/trap entry: clear IF and TF
//  FLAGS          out  16  architectural FLAGS (registered)
//  carryFlag      out  1   FLAGS[0], drives ALU carryIn
//  dirFlag        out  1   FLAGS[10]
//  intEnable      out  1   FLAGS[9]
//  trapFlag       out  1   FLAGS[8]
//  flagsPending   out  1   any ALU update in flight (registered stages only)
// BEHAVIOUR
//  - Reset (async): FLAGS = RESERVED_ONES (F002). Pending pipe cleared.
//    flagsPending = 0.
//  - Bit map: CF0 PF2 AF4 ZF6 SF7 TF8 IF9 DF10 OF11.
//    Bits 15:12 and 1 always read 1; bits 5 and 3 always read 0.
//  - Pending pipe: ALU_FLAG_LATENCY stages of {valid, class}.
//    Stage 1 loads {aluIssue & class!=0, aluClass}.
//  - An op issued in cycle n commits at the edge ending cycle n+ALU_FLAG_LATENCY.
//    FLAGS is visible from cycle n+ALU_FLAG_LATENCY+1.
//  - flagsPending = OR of all stage valids. The sequencer stalls ADC/SBB/Jcc/
//    LAHF/PUSHF while it is high. This block does no bypass.
//  - Commit per class:
//    * ARITH: OF,SF,ZF,AF,PF,CF all from ALU.
//    * INCDEC: same, but CF kept.
//    * LOGIC: SF,ZF,PF from ALU; OF=CF=AF=0.
//    * none: no change.
//  - Same-edge priority, applied in order (later wins; program order):
//    (1) ALU commit, (2) masked flagWrite, (3) flagOp, (4) intEntry.
//    CMC toggles the CF produced by (1)/(2) on the same edge.
//  - flagWrite/flagOp never cancel in-flight ALU updates. Issuing them while
//    flagsPending=1 is a sequencer error; behaviour follows the priority order.
//  - Reserved bits ignore flagWrite.
//  - RESET asserted mid-flight drops all pending commits; none applies after
//    release.
// STRUCTURE
//  - flags_pkg: bit-index localparams, class and flagOp encodings,
//    RESERVED_ONES and reserved mask (16'h0028 zero bits).
//  - Sub-module flags_pend_pipe: parameterised {valid,class} delay line with
//    async reset. Exposes the last stage and an any-valid output.
//  - Merge/priority logic stays in flags_unit.
// TESTING
//  1. Reset -> FLAGS=F002, flagsPending=0, carryFlag=0.
//  2. ARITH issue at n; F_Carry=1, F_Zero=1, others 0 at n+2
//     -> FLAGS=F043 at n+3; flagsPending high n+1..n+2.
//  3. CF=1, INCDEC issue; ALU gives F_Carry=0, F_Neg=1 -> FLAGS=F083 (CF kept).
//  4. flagWrite data FFFF mask FFFF -> FLAGS=FFD7;
//     then SAHF data 0000 mask 00D5 -> FLAGS=FF02.
//  5. ARITH commit with F_Carry=1 plus CMC on the same edge -> CF=0;
//     commit plus STI plus intEntry -> IF=0, TF=0.
//  6. Issue ARITH, assert RESET at n+1 for one cycle -> FLAGS stays F002 at
//     n+3, flagsPending=0.

Source files
------------

// File: rtl/flags_pkg.sv
// Shared definitions for the 8088 FLAGS unit.
//   - Bit positions of the architectural flags inside the 16-bit FLAGS word.
//   - ALU update-class and single-flag-op encodings.
//   - Reserved-bit constants and a helper that forces them.
package flags_pkg;

  localparam int unsigned CF_BIT = 0;
  localparam int unsigned PF_BIT = 2;
  localparam int unsigned AF_BIT = 4;
  localparam int unsigned ZF_BIT = 6;
  localparam int unsigned SF_BIT = 7;
  localparam int unsigned TF_BIT = 8;
  localparam int unsigned IF_BIT = 9;
  localparam int unsigned DF_BIT = 10;
  localparam int unsigned OF_BIT = 11;

  // Bits 15:12 and 1 always read 1; bits 5 and 3 always read 0.
  localparam logic [15:0] RESERVED_ONES_DEF = 16'hF002;
  localparam logic [15:0] RESERVED_ZEROS    = 16'h0028;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'b00,
    CLS_ARITH  = 2'b01,
    CLS_INCDEC = 2'b10,
    CLS_LOGIC  = 2'b11
  } alu_class_e;

  typedef enum logic [2:0] {
    FOP_NONE = 3'd0,
    FOP_CLC  = 3'd1,
    FOP_STC  = 3'd2,
    FOP_CMC  = 3'd3,
    FOP_CLD  = 3'd4,
    FOP_STD  = 3'd5,
    FOP_CLI  = 3'd6,
    FOP_STI  = 3'd7
  } flag_op_e;

  function automatic logic [15:0] force_reserved(input logic [15:0] f,
                                                 input logic [15:0] ones);
    return (f | ones) & ~RESERVED_ZEROS;
  endfunction

endpackage

// File: rtl/flags_pend_pipe.sv
// Delay line carrying {valid, class} of issued ALU ops until their flag
// outputs are ready.
// Ports:
//   clk_i       clock (posedge)
//   rst_i       asynchronous active-high reset, clears all valids
//   vld_i       op with a non-none class issued this cycle
//   cls_i       update class of that op
//   last_vld_o  valid of the final stage (commit this edge)
//   last_cls_o  class of the final stage
//   any_vld_o   OR of all stage valids
module flags_pend_pipe
  import flags_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       vld_i,
  input  alu_class_e cls_i,
  output logic       last_vld_o,
  output alu_class_e last_cls_o,
  output logic       any_vld_o
);

  logic [STAGES-1:0] vld_q;
  alu_class_e        cls_q [STAGES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      for (int i = 1; i < STAGES; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Class only matters when its valid is set, so it carries no reset.
  always_ff @(posedge clk_i) begin
    cls_q[0] <= cls_i;
    for (int i = 1; i < STAGES; i++) cls_q[i] <= cls_q[i-1];
  end

  assign last_vld_o = vld_q[STAGES-1];
  assign last_cls_o = cls_q[STAGES-1];
  assign any_vld_o  = |vld_q;

endmodule

// File: rtl/flags_unit.sv
// 8088 FLAGS register. Merges delayed ALU status outputs by update class,
// then applies direct writes (POPF/SAHF), single-flag ops and interrupt
// entry, in that order on the same edge.
// Ports:
//   CLKx4          clock, all state on posedge
//   RESET          asynchronous active-high reset
//   aluIssue       ALU op presented this cycle
//   aluClass       00 none, 01 ARITH, 10 INCDEC, 11 LOGIC
//   F_Overflow, F_Neg, F_Zero, F_AuxCarry, F_Parity, F_Carry
//                  ALU flag outputs, valid ALU_FLAG_LATENCY edges after issue
//   flagWrite      masked direct write enable
//   flagWriteData  data for direct write
//   flagWriteMask  bits replaced by direct write
//   flagOp         0 none, CLC, STC, CMC, CLD, STD, CLI, STI
//   intEntry       interrupt/trap entry: clears IF and TF
//   FLAGS          architectural FLAGS (registered)
//   carryFlag, dirFlag, intEnable, trapFlag  individual flag taps
//   flagsPending   any ALU update still in flight
module flags_unit
  import flags_pkg::*;
#(
  parameter int unsigned ALU_FLAG_LATENCY = 2,
  parameter logic [15:0] RESERVED_ONES    = RESERVED_ONES_DEF
) (
  input  logic        CLKx4,
  input  logic        RESET,
  input  logic        aluIssue,
  input  logic [1:0]  aluClass,
  input  logic        F_Overflow,
  input  logic        F_Neg,
  input  logic        F_Zero,
  input  logic        F_AuxCarry,
  input  logic        F_Parity,
  input  logic        F_Carry,
  input  logic        flagWrite,
  input  logic [15:0] flagWriteData,
  input  logic [15:0] flagWriteMask,
  input  logic [2:0]  flagOp,
  input  logic        intEntry,
  output logic [15:0] FLAGS,
  output logic        carryFlag,
  output logic        dirFlag,
  output logic        intEnable,
  output logic        trapFlag,
  output logic        flagsPending
);

  alu_class_e  issue_cls;
  logic        commit_vld;
  alu_class_e  commit_cls;
  logic [15:0] flags_q;
  logic [15:0] flags_d;

  assign issue_cls = alu_class_e'(aluClass);

  flags_pend_pipe #(
    .STAGES (ALU_FLAG_LATENCY)
  ) u_pend (
    .clk_i      (CLKx4),
    .rst_i      (RESET),
    .vld_i      (aluIssue && (issue_cls != CLS_NONE)),
    .cls_i      (issue_cls),
    .last_vld_o (commit_vld),
    .last_cls_o (commit_cls),
    .any_vld_o  (flagsPending)
  );

  // Each step below overrides the previous one, matching program order.
  always_comb begin
    flags_d = flags_q;

    if (commit_vld) begin
      case (commit_cls)
        CLS_ARITH, CLS_INCDEC: begin
          flags_d[OF_BIT] = F_Overflow;
          flags_d[SF_BIT] = F_Neg;
          flags_d[ZF_BIT] = F_Zero;
          flags_d[AF_BIT] = F_AuxCarry;
          flags_d[PF_BIT] = F_Parity;
          // INC/DEC preserve CF.
          if (commit_cls == CLS_ARITH) flags_d[CF_BIT] = F_Carry;
        end
        CLS_LOGIC: begin
          flags_d[OF_BIT] = 1'b0;
          flags_d[SF_BIT] = F_Neg;
          flags_d[ZF_BIT] = F_Zero;
          flags_d[AF_BIT] = 1'b0;
          flags_d[PF_BIT] = F_Parity;
          flags_d[CF_BIT] = 1'b0;
        end
        default: ;
      endcase
    end

    if (flagWrite) begin
      flags_d = (flags_d & ~flagWriteMask) | (flagWriteData & flagWriteMask);
    end

    case (flag_op_e'(flagOp))
      FOP_CLC: flags_d[CF_BIT] = 1'b0;
      FOP_STC: flags_d[CF_BIT] = 1'b1;
      FOP_CMC: flags_d[CF_BIT] = ~flags_d[CF_BIT];
      FOP_CLD: flags_d[DF_BIT] = 1'b0;
      FOP_STD: flags_d[DF_BIT] = 1'b1;
      FOP_CLI: flags_d[IF_BIT] = 1'b0;
      FOP_STI: flags_d[IF_BIT] = 1'b1;
      default: ;
    endcase

    if (intEntry) begin
      flags_d[IF_BIT] = 1'b0;
      flags_d[TF_BIT] = 1'b0;
    end

    // Reserved bits are fixed regardless of what was written above.
    flags_d = force_reserved(flags_d, RESERVED_ONES);
  end

  always_ff @(posedge CLKx4 or posedge RESET) begin
    if (RESET) flags_q <= RESERVED_ONES;
    else       flags_q <= flags_d;
  end

  assign FLAGS     = flags_q;
  assign carryFlag = flags_q[CF_BIT];
  assign dirFlag   = flags_q[DF_BIT];
  assign intEnable = flags_q[IF_BIT];
  assign trapFlag  = flags_q[TF_BIT];

endmodule

// File: tb/tb_flags_unit.sv
module tb_flags_unit;

  localparam int LAT = 2;

  logic        CLKx4 = 1'b0;
  logic        RESET;
  logic        aluIssue;
  logic [1:0]  aluClass;
  logic        F_Overflow, F_Neg, F_Zero, F_AuxCarry, F_Parity, F_Carry;
  logic        flagWrite;
  logic [15:0] flagWriteData, flagWriteMask;
  logic [2:0]  flagOp;
  logic        intEntry;
  logic [15:0] FLAGS;
  logic        carryFlag, dirFlag, intEnable, trapFlag, flagsPending;

  flags_unit #(.ALU_FLAG_LATENCY(LAT), .RESERVED_ONES(16'hF002)) dut (
    .CLKx4(CLKx4), .RESET(RESET), .aluIssue(aluIssue), .aluClass(aluClass),
    .F_Overflow(F_Overflow), .F_Neg(F_Neg), .F_Zero(F_Zero),
    .F_AuxCarry(F_AuxCarry), .F_Parity(F_Parity), .F_Carry(F_Carry),
    .flagWrite(flagWrite), .flagWriteData(flagWriteData),
    .flagWriteMask(flagWriteMask), .flagOp(flagOp), .intEntry(intEntry),
    .FLAGS(FLAGS), .carryFlag(carryFlag), .dirFlag(dirFlag),
    .intEnable(intEnable), .trapFlag(trapFlag), .flagsPending(flagsPending)
  );

  always #5 CLKx4 = ~CLKx4;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Reference model: expected FLAGS plus a schedule of commits indexed by
  // the absolute cycle in which each issued op's flags land.
  logic [15:0] exp_flags;
  bit          sched_vld [0:4095];
  logic [1:0]  sched_cls [0:4095];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic bit exp_pending();
    bit p = 1'b0;
    for (int k = 0; k < LAT; k++) p |= sched_vld[cyc + k];
    return p;
  endfunction

  function automatic logic [15:0] ref_next(input logic [15:0] f);
    logic [15:0] n = f;
    if (sched_vld[cyc]) begin
      case (sched_cls[cyc])
        2'b01: begin
          n[11] = F_Overflow; n[7] = F_Neg; n[6] = F_Zero;
          n[4] = F_AuxCarry;  n[2] = F_Parity; n[0] = F_Carry;
        end
        2'b10: begin
          n[11] = F_Overflow; n[7] = F_Neg; n[6] = F_Zero;
          n[4] = F_AuxCarry;  n[2] = F_Parity;
        end
        2'b11: begin
          n[11] = 1'b0; n[7] = F_Neg; n[6] = F_Zero;
          n[4] = 1'b0;  n[2] = F_Parity; n[0] = 1'b0;
        end
        default: ;
      endcase
    end
    if (flagWrite) n = (n & ~flagWriteMask) | (flagWriteData & flagWriteMask);
    if (flagOp == 3'd1) n[0] = 1'b0;
    if (flagOp == 3'd2) n[0] = 1'b1;
    if (flagOp == 3'd3) n[0] = ~n[0];
    if (flagOp == 3'd4) n[10] = 1'b0;
    if (flagOp == 3'd5) n[10] = 1'b1;
    if (flagOp == 3'd6) n[9] = 1'b0;
    if (flagOp == 3'd7) n[9] = 1'b1;
    if (intEntry) begin n[9] = 1'b0; n[8] = 1'b0; end
    return (n | 16'hF002) & 16'hFFD7;
  endfunction

  task automatic model_reset();
    exp_flags = 16'hF002;
    for (int k = cyc; k <= cyc + LAT; k++) sched_vld[k] = 1'b0;
  endtask

  task automatic clr_inputs();
    aluIssue = 0; aluClass = 0;
    {F_Overflow, F_Neg, F_Zero, F_AuxCarry, F_Parity, F_Carry} = '0;
    flagWrite = 0; flagWriteData = 0; flagWriteMask = 0;
    flagOp = 0; intEntry = 0;
  endtask

  // One clock: update the model for the edge ending this cycle, then compare.
  task automatic step();
    if (RESET) begin
      model_reset();
    end else begin
      exp_flags = ref_next(exp_flags);
      if (aluIssue && aluClass != 2'b00) begin
        sched_vld[cyc + LAT] = 1'b1;
        sched_cls[cyc + LAT] = aluClass;
      end
    end
    @(posedge CLKx4); #1;
    cyc++;
    check("model_flags", FLAGS, exp_flags);
    check("model_pend", {15'b0, flagsPending}, {15'b0, exp_pending()});
    check("model_taps", {12'b0, carryFlag, dirFlag, intEnable, trapFlag},
          {12'b0, exp_flags[0], exp_flags[10], exp_flags[9], exp_flags[8]});
  endtask

  task automatic issue(input logic [1:0] cls);
    clr_inputs(); aluIssue = 1; aluClass = cls;
    step();
    clr_inputs();
  endtask

  initial begin
    for (int k = 0; k < 4096; k++) begin sched_vld[k] = 1'b0; sched_cls[k] = 2'b00; end
    clr_inputs();
    RESET = 1'b1;
    exp_flags = 16'hF002;
    @(posedge CLKx4); #1;

    // Reset state
    check("rst_flags", FLAGS, 16'hF002);
    check("rst_pend", {15'b0, flagsPending}, 16'h0);
    check("rst_cf", {15'b0, carryFlag}, 16'h0);
    step();
    RESET = 1'b0;
    step();

    // ARITH: CF=1, ZF=1
    issue(2'b01);
    check("arith_pend_n1", {15'b0, flagsPending}, 16'h1);
    step();
    check("arith_pend_n2", {15'b0, flagsPending}, 16'h1);
    F_Carry = 1; F_Zero = 1;
    step();
    clr_inputs();
    check("arith_flags", FLAGS, 16'hF043);
    check("arith_pend_n3", {15'b0, flagsPending}, 16'h0);

    // INCDEC keeps CF
    issue(2'b10);
    step();
    F_Carry = 0; F_Neg = 1;
    step();
    clr_inputs();
    check("incdec_flags", FLAGS, 16'hF083);

    // POPF all ones, then SAHF zeros
    flagWrite = 1; flagWriteData = 16'hFFFF; flagWriteMask = 16'hFFFF;
    step();
    clr_inputs();
    check("popf_flags", FLAGS, 16'hFFD7);
    flagWrite = 1; flagWriteData = 16'h0000; flagWriteMask = 16'h00D5;
    step();
    clr_inputs();
    check("sahf_flags", FLAGS, 16'hFF02);

    // ARITH commit with CMC on the same edge
    issue(2'b01);
    step();
    F_Carry = 1; flagOp = 3'd3;
    step();
    clr_inputs();
    check("cmc_cf", {15'b0, carryFlag}, 16'h0);

    // ARITH commit with STI and intEntry on the same edge
    issue(2'b01);
    step();
    F_Carry = 1; flagOp = 3'd7; intEntry = 1;
    step();
    clr_inputs();
    check("int_if", {15'b0, intEnable}, 16'h0);
    check("int_tf", {15'b0, trapFlag}, 16'h0);
    check("int_cf", {15'b0, carryFlag}, 16'h1);

    // RESET mid-flight drops the pending commit
    issue(2'b01);
    RESET = 1'b1; #1;
    model_reset();
    check("midrst_flags", FLAGS, 16'hF002);
    check("midrst_pend", {15'b0, flagsPending}, 16'h0);
    step();
    RESET = 1'b0;
    F_Carry = 1; F_Zero = 1; F_Overflow = 1;
    step();
    clr_inputs();
    check("midrst_n3_flags", FLAGS, 16'hF002);
    check("midrst_n3_pend", {15'b0, flagsPending}, 16'h0);

    // Randomised traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      clr_inputs();
      if ($urandom_range(0, 63) == 0) begin
        RESET = 1'b1; #1;
        model_reset();
        check("rand_async_rst", FLAGS, 16'hF002);
        step();
        RESET = 1'b0;
      end else begin
        aluIssue = 1'($urandom_range(0, 1));
        aluClass = 2'($urandom_range(0, 3));
        {F_Overflow, F_Neg, F_Zero, F_AuxCarry, F_Parity, F_Carry} = 6'($urandom_range(0, 63));
        flagWrite = ($urandom_range(0, 7) == 0);
        flagWriteData = 16'($urandom);
        flagWriteMask = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
        flagOp = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        intEntry = ($urandom_range(0, 15) == 0);
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
